iter_div_core: RTL and testbench



---
 rtl/iter_div_core.sv | 143 ++++++++++++++
 tb/tb_iter_div_core.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_div_core.sv
// Multi-cycle radix-2 restoring divider with AXI-stream-style operand inputs and a
// one-cycle result strobe. SIGNED selects two's-complement (div) or unsigned (divu).
module iter_div_core #(
    parameter int unsigned SIGNED = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] s_axis_divisor_tdata,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    output logic [63:0] m_axis_dout_tdata,
    output logic        m_axis_dout_tvalid
);

    localparam bit IsSigned = (SIGNED != 0);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic        dvs_flag_q, dvs_flag_d;
    logic        dvd_flag_q, dvd_flag_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [63:0] dout_q, dout_d;
    logic        dout_valid_q, dout_valid_d;

    logic        dvs_fire, dvd_fire;
    logic [31:0] dvs_raw, dvd_raw;
    logic [32:0] partial, trial;
    logic        qbit;
    logic [31:0] rem_next, quo_next;

    function automatic logic [31:0] mag(input logic [31:0] x);
        return (IsSigned && x[31]) ? (~x + 32'd1) : x;
    endfunction

    assign s_axis_divisor_tready  = (state_q == StIdle) && !dvs_flag_q;
    assign s_axis_dividend_tready = (state_q == StIdle) && !dvd_flag_q;
    assign m_axis_dout_tdata      = dout_q;
    assign m_axis_dout_tvalid     = dout_valid_q;

    // During CALC dvd_q doubles as the dividend shift-out / quotient shift-in register.
    always_comb begin
        dvs_fire = (state_q == StIdle) && s_axis_divisor_tvalid && !dvs_flag_q;
        dvd_fire = (state_q == StIdle) && s_axis_dividend_tvalid && !dvd_flag_q;
        dvs_raw  = dvs_fire ? s_axis_divisor_tdata : dvs_q;
        dvd_raw  = dvd_fire ? s_axis_dividend_tdata : dvd_q;
        partial  = {rem_q, dvd_q[31]};
        trial    = partial - {1'b0, dvs_q};
        qbit     = ~trial[32];
        rem_next = qbit ? trial[31:0] : partial[31:0];
        quo_next = {dvd_q[30:0], qbit};
    end

    always_comb begin
        state_d      = state_q;
        dvs_flag_d   = dvs_flag_q;
        dvd_flag_d   = dvd_flag_q;
        dvs_d        = dvs_q;
        dvd_d        = dvd_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        qneg_d       = qneg_q;
        rneg_d       = rneg_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (dvs_fire) begin
                    dvs_flag_d = 1'b1;
                    dvs_d      = s_axis_divisor_tdata;
                end
                if (dvd_fire) begin
                    dvd_flag_d = 1'b1;
                    dvd_d      = s_axis_dividend_tdata;
                end
                if ((dvs_flag_q || dvs_fire) && (dvd_flag_q || dvd_fire)) begin
                    state_d = StCalc;
                    dvs_d   = mag(dvs_raw);
                    dvd_d   = mag(dvd_raw);
                    rem_d   = 32'd0;
                    cnt_d   = 5'd0;
                    qneg_d  = IsSigned && (dvd_raw[31] ^ dvs_raw[31]);
                    rneg_d  = IsSigned && dvd_raw[31];
                end
            end
            StCalc: begin
                rem_d = rem_next;
                dvd_d = quo_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d      = StDone;
                    cnt_d        = 5'd0;
                    dout_d       = {qneg_q ? (~quo_next + 32'd1) : quo_next,
                                    rneg_q ? (~rem_next + 32'd1) : rem_next};
                    dout_valid_d = 1'b1;
                end
            end
            StDone: begin
                state_d    = StIdle;
                dvs_flag_d = 1'b0;
                dvd_flag_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            dvs_flag_q   <= 1'b0;
            dvd_flag_q   <= 1'b0;
            dvs_q        <= 32'd0;
            dvd_q        <= 32'd0;
            rem_q        <= 32'd0;
            cnt_q        <= 5'd0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            dout_q       <= 64'd0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dvs_flag_q   <= dvs_flag_d;
            dvd_flag_q   <= dvd_flag_d;
            dvs_q        <= dvs_d;
            dvd_q        <= dvd_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            qneg_q       <= qneg_d;
            rneg_q       <= rneg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

endmodule

// File: tb/tb_iter_div_core.sv
// Bench for iter_div_core: an unsigned and a signed instance driven in lockstep, results
// checked against a behavioural divide model through per-instance scoreboards.
module tb_iter_div_core;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] dvs_data, dvd_data;
    logic        dvs_valid, dvd_valid;
    logic        u_dvs_rdy, u_dvd_rdy, u_vld;
    logic        s_dvs_rdy, s_dvd_rdy, s_vld;
    logic [63:0] u_dout, s_dout;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_u_q[$];
    logic [63:0] exp_s_q[$];

    always #5 clk = ~clk;

    iter_div_core #(.SIGNED(0)) u_dut_u (
        .clk                    (clk),
        .resetn                 (rstn),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (u_dvs_rdy),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (u_dvd_rdy),
        .m_axis_dout_tdata      (u_dout),
        .m_axis_dout_tvalid     (u_vld)
    );

    iter_div_core #(.SIGNED(1)) u_dut_s (
        .clk                    (clk),
        .resetn                 (rstn),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (s_dvs_rdy),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (s_dvd_rdy),
        .m_axis_dout_tdata      (s_dout),
        .m_axis_dout_tvalid     (s_vld)
    );

    function automatic logic [63:0] model_u(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {32'hFFFFFFFF, a};
        return {a / b, a % b};
    endfunction

    function automatic logic [63:0] model_s(input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return {(a[31] ? 32'h00000001 : 32'hFFFFFFFF), a};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h80000000, 32'h0};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {q, r};
    endfunction

    // Scoreboard: every strobe must match the oldest expected result.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (u_vld === 1'b1) begin
                n_checks++;
                if (exp_u_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unsigned: got strobe %h, required no strobe", u_dout);
                end else begin
                    logic [63:0] e;
                    e = exp_u_q.pop_front();
                    if (u_dout !== e) begin
                        n_fail++;
                        $display("FAIL sb_unsigned: got %h, required %h", u_dout, e);
                    end
                end
            end
            if (s_vld === 1'b1) begin
                n_checks++;
                if (exp_s_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_signed: got strobe %h, required no strobe", s_dout);
                end else begin
                    logic [63:0] e;
                    e = exp_s_q.pop_front();
                    if (s_dout !== e) begin
                        n_fail++;
                        $display("FAIL sb_signed: got %h, required %h", s_dout, e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
        exp_u_q.push_back(model_u(a, b));
        exp_s_q.push_back(model_s(a, b));
    endtask

    // Handshake both operands in the current cycle, return cycles until the strobe.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        dvd_data  = a;
        dvs_data  = b;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        push_exp(a, b);
        step();
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        lat = 1;
        while (u_vld !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        dvs_valid = 1'b0;
        dvd_valid = 1'b0;
        dvs_data = 32'd0;
        dvd_data = 32'd0;
        step();
        step();
        n_checks += 4;
        if (u_vld !== 1'b0 || s_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tvalid: got %b/%b, required 0/0", u_vld, s_vld);
        end
        if (u_dout !== 64'd0 || s_dout !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_tdata: got %h/%h, required 0", u_dout, s_dout);
        end
        if (u_dvs_rdy !== 1'b1 || s_dvs_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_dvs_ready: got %b/%b, required 1/1", u_dvs_rdy, s_dvs_rdy);
        end
        if (u_dvd_rdy !== 1'b1 || s_dvd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_dvd_ready: got %b/%b, required 1/1", u_dvd_rdy, s_dvd_rdy);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        dvd_data  = 32'd100;
        dvs_data  = 32'd7;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        push_exp(32'd100, 32'd7);
        step();
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            n_checks += 2;
            if (u_vld !== (c == 33) || s_vld !== (c == 33)) begin
                n_fail++;
                $display("FAIL basic_tvalid c%0d: got %b/%b, required %b", c, u_vld, s_vld,
                         (c == 33));
            end
            if (u_dvs_rdy !== 1'b0 || u_dvd_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_busy_ready c%0d: got %b/%b, required 0/0", c, u_dvs_rdy,
                         u_dvd_rdy);
            end
            if (c < 33) step();
        end
        n_checks++;
        if (u_dout !== {32'h0000000E, 32'h00000002}) begin
            n_fail++;
            $display("FAIL basic_tdata: got %h, required 0000000e00000002", u_dout);
        end
        step();
        n_checks++;
        if (u_dvs_rdy !== 1'b1 || u_dvd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready_c34: got %b/%b, required 1/1", u_dvs_rdy, u_dvd_rdy);
        end
    endtask

    task automatic test_signed();
        logic [31:0] a_tab[3];
        logic [31:0] b_tab[3];
        logic [63:0] r_tab[3];
        int          lat;
        a_tab = '{32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFF9};
        b_tab = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFE};
        r_tab = '{{32'hFFFFFFFD, 32'hFFFFFFFF}, {32'hFFFFFFFD, 32'h00000001},
                  {32'h00000003, 32'hFFFFFFFF}};
        for (int i = 0; i < 3; i++) begin
            do_op(a_tab[i], b_tab[i], lat);
            n_checks += 2;
            if (lat != 33) begin
                n_fail++;
                $display("FAIL signed_latency %0d: got %0d, required 33", i, lat);
            end
            if (s_dout !== r_tab[i]) begin
                n_fail++;
                $display("FAIL signed_tdata %0d: got %h, required %h", i, s_dout, r_tab[i]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] a_tab[4];
        logic [31:0] b_tab[4];
        logic [63:0] r_tab[4];
        logic        sgn_tab[4];
        int          lat;
        a_tab   = '{32'h80000000, 32'h12345678, 32'hFFFFFFF9, 32'hFFFFFFFF};
        b_tab   = '{32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000001};
        r_tab   = '{{32'h80000000, 32'h00000000}, {32'hFFFFFFFF, 32'h12345678},
                    {32'h00000001, 32'hFFFFFFF9}, {32'hFFFFFFFF, 32'h00000000}};
        sgn_tab = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            logic [63:0] got;
            do_op(a_tab[i], b_tab[i], lat);
            got = sgn_tab[i] ? s_dout : u_dout;
            n_checks += 2;
            if (lat != 33) begin
                n_fail++;
                $display("FAIL boundary_latency %0d: got %0d, required 33", i, lat);
            end
            if (got !== r_tab[i]) begin
                n_fail++;
                $display("FAIL boundary_tdata %0d: got %h, required %h", i, got, r_tab[i]);
            end
        end
    endtask

    task automatic test_split();
        int c;
        dvs_data  = 32'd3;
        dvs_valid = 1'b1;
        step();
        dvs_data = 32'd99;
        for (int k = 1; k <= 5; k++) begin
            n_checks += 2;
            if (u_dvs_rdy !== 1'b0 || s_dvs_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL split_dvs_ready c%0d: got %b/%b, required 0/0", k, u_dvs_rdy,
                         s_dvs_rdy);
            end
            if (u_dvd_rdy !== 1'b1 || s_dvd_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL split_dvd_ready c%0d: got %b/%b, required 1/1", k, u_dvd_rdy,
                         s_dvd_rdy);
            end
            if (k < 5) step();
        end
        dvd_data  = 32'd10;
        dvd_valid = 1'b1;
        push_exp(32'd10, 32'd3);
        step();
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        c = 6;
        while (u_vld !== 1'b1 && c < 60) begin
            step();
            c++;
        end
        n_checks += 2;
        if (c != 38) begin
            n_fail++;
            $display("FAIL split_strobe_cycle: got %0d, required 38", c);
        end
        if (u_dout !== {32'd3, 32'd1}) begin
            n_fail++;
            $display("FAIL split_tdata: got %h, required 0000000300000001", u_dout);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0] res_u, res_s;
        res_u = model_u(32'd1000, 32'd9);
        res_s = model_s(32'd1000, 32'd9);
        dvd_data  = 32'd1000;
        dvs_data  = 32'd9;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        push_exp(32'd1000, 32'd9);
        step();
        for (int c = 1; c <= 33; c++) begin
            dvd_data = $urandom;
            dvs_data = $urandom;
            n_checks++;
            if (u_vld !== (c == 33) || s_vld !== (c == 33)) begin
                n_fail++;
                $display("FAIL b2b_first_tvalid c%0d: got %b/%b, required %b", c, u_vld,
                         s_vld, (c == 33));
            end
            step();
        end
        dvd_data = 32'hDEADBEEF;
        dvs_data = 32'h00001234;
        push_exp(32'hDEADBEEF, 32'h00001234);
        n_checks++;
        if (u_dvs_rdy !== 1'b1 || u_dvd_rdy !== 1'b1 || s_dvs_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept_c34: got %b/%b/%b, required 1/1/1", u_dvs_rdy,
                     u_dvd_rdy, s_dvs_rdy);
        end
        for (int c = 34; c <= 67; c++) begin
            n_checks++;
            if (u_vld !== (c == 67) || s_vld !== (c == 67)) begin
                n_fail++;
                $display("FAIL b2b_second_tvalid c%0d: got %b/%b, required %b", c, u_vld,
                         s_vld, (c == 67));
            end
            if (c < 67) begin
                n_checks++;
                if (u_dout !== res_u || s_dout !== res_s) begin
                    n_fail++;
                    $display("FAIL b2b_hold c%0d: got %h/%h, required %h/%h", c, u_dout,
                             s_dout, res_u, res_s);
                end
            end
            step();
            if (c == 34) begin
                dvd_valid = 1'b0;
                dvs_valid = 1'b0;
            end
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        dvd_data  = 32'd50;
        dvs_data  = 32'd6;
        dvd_valid = 1'b1;
        dvs_valid = 1'b1;
        step();
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        for (int c = 1; c < 12; c++) step();
        #2;
        rstn = 1'b0;
        #1;
        n_checks += 3;
        if (u_vld !== 1'b0 || s_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_tvalid: got %b/%b, required 0/0", u_vld, s_vld);
        end
        if (u_dout !== 64'd0 || s_dout !== 64'd0) begin
            n_fail++;
            $display("FAIL midrst_tdata: got %h/%h, required 0", u_dout, s_dout);
        end
        if (u_dvs_rdy !== 1'b1 || u_dvd_rdy !== 1'b1 || s_dvs_rdy !== 1'b1 ||
            s_dvd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready: got %b%b%b%b, required 1111", u_dvs_rdy, u_dvd_rdy,
                     s_dvs_rdy, s_dvd_rdy);
        end
        step();
        rstn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            n_checks++;
            if (u_vld !== 1'b0 || s_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_stale_strobe c%0d: got %b/%b, required 0/0", c, u_vld,
                         s_vld);
            end
            step();
        end
        do_op(32'd9, 32'd4, lat);
        n_checks += 2;
        if (lat != 33) begin
            n_fail++;
            $display("FAIL midrst_fresh_latency: got %0d, required 33", lat);
        end
        if (u_dout !== {32'd2, 32'd1} || s_dout !== {32'd2, 32'd1}) begin
            n_fail++;
            $display("FAIL midrst_fresh_tdata: got %h/%h, required 0000000200000001", u_dout,
                     s_dout);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_boundary();
        test_split();
        test_back_to_back();
        test_mid_reset();
        step();
        n_checks++;
        if (exp_u_q.size() != 0 || exp_s_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d/%0d pending, required 0/0", exp_u_q.size(),
                     exp_s_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
